// File: rtl/agc_pkg.sv
// Shared AGC definitions: envelope FSM states, default widths and the
// accumulator width helper used by the EMA envelope follower.
package agc_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TRACK  = 2'd2
    } ema_state_e;

    localparam int W_MAG       = 27;
    localparam int ALPHA_SHIFT = 4;

    // Accumulator holds envelope * 2^s, so it needs s extra integer bits.
    function automatic int ema_acc_width(input int w, input int s);
        return w + s;
    endfunction

endpackage

// File: rtl/ema_settle_ctr.sv
// Saturating up-counter with synchronous clear. at_last_o flags that the
// next increment will land on the terminal count SETTLE_LEN.
module ema_settle_ctr #(
    parameter int SETTLE_LEN = 64,
    parameter int CW         = $clog2(SETTLE_LEN + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_last_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise step up until the terminal count.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CW'(SETTLE_LEN))) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_last_o = (count_q == CW'(SETTLE_LEN - 1));

endmodule

// File: rtl/ema_envelope.sv
// Exponential-moving-average envelope follower for the AGC path.
// Smooths an unsigned magnitude stream with coefficient 2^-ALPHA_SHIFT and
// flags when SETTLE_LEN updates have followed the seed sample.
// Optional build macro EMA_ROUND_EN: round-half-up with output saturation
// on env_o instead of plain truncation (accumulator unchanged).
//
// Handshake: valid_i marks a new mag_i sample, there is no backpressure;
// valid_o pulses for one cycle, one cycle after each accepted sample, and
// env_o holds its value between pulses.
module ema_envelope
    import agc_pkg::*;
#(
    parameter int W_IN        = W_MAG,
    parameter int ALPHA_SHIFT = agc_pkg::ALPHA_SHIFT,
    parameter int SETTLE_LEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            valid_i,
    input  logic [W_IN-1:0] mag_i,
    output logic            valid_o,
    output logic [W_IN-1:0] env_o,
    output logic            settled_o
);

    localparam int AW = ema_acc_width(W_IN, ALPHA_SHIFT);

    ema_state_e      state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [W_IN-1:0] env_q, env_d;
    logic            valid_q, valid_d;
    logic            settled_q, settled_d;

    logic [AW-1:0]   mag_ext;
    logic [AW-1:0]   acc_nx;
    logic [W_IN-1:0] env_nx;
    logic            ctr_clr;
    logic            ctr_inc;
    logic            ctr_at_last;

    ema_settle_ctr #(
        .SETTLE_LEN (SETTLE_LEN)
    ) u_settle_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ctr_clr),
        .inc_i     (ctr_inc),
        .at_last_o (ctr_at_last)
    );

    // Candidate accumulator value: seed loads the scaled sample, otherwise
    // the EMA update (bounded, so it never overflows AW bits).
    always_comb begin
        mag_ext = AW'(mag_i);
        if (state_q == ST_SEED) begin
            acc_nx = mag_ext << ALPHA_SHIFT;
        end else begin
            acc_nx = acc_q - (acc_q >> ALPHA_SHIFT) + mag_ext;
        end
    end

`ifdef EMA_ROUND_EN
    localparam logic [AW:0] HALF = (AW + 1)'(1) << (ALPHA_SHIFT - 1);
    logic [AW:0]   rnd_sum;
    logic [W_IN:0] rnd_sh;

    // Envelope from the candidate: round half up, saturate at full scale.
    always_comb begin
        rnd_sum = {1'b0, acc_nx} + HALF;
        rnd_sh  = (W_IN + 1)'(rnd_sum >> ALPHA_SHIFT);
        if (rnd_sh[W_IN]) begin
            env_nx = '1;
        end else begin
            env_nx = rnd_sh[W_IN-1:0];
        end
    end
`else
    // Envelope from the candidate: plain truncation.
    always_comb begin
        env_nx = W_IN'(acc_nx >> ALPHA_SHIFT);
    end
`endif

    // FSM next state and datapath register loads; clear beats a sample.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        env_d     = env_q;
        valid_d   = 1'b0;
        settled_d = settled_q;
        ctr_clr   = 1'b0;
        ctr_inc   = 1'b0;
        if (clear_i) begin
            state_d   = ST_SEED;
            acc_d     = '0;
            env_d     = '0;
            settled_d = 1'b0;
            ctr_clr   = 1'b1;
        end else if (valid_i) begin
            valid_d = 1'b1;
            acc_d   = acc_nx;
            env_d   = env_nx;
            case (state_q)
                ST_SEED: begin
                    ctr_clr = 1'b1;
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    ctr_inc = 1'b1;
                    if (ctr_at_last) begin
                        state_d   = ST_TRACK;
                        settled_d = 1'b1;
                    end
                end
                ST_TRACK: begin
                    ctr_inc = 1'b1;
                end
                default: begin
                    state_d = ST_SEED;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SEED;
            acc_q     <= '0;
            env_q     <= '0;
            valid_q   <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            env_q     <= env_d;
            valid_q   <= valid_d;
            settled_q <= settled_d;
        end
    end

    assign valid_o   = valid_q;
    assign env_o     = env_q;
    assign settled_o = settled_q;

endmodule

// File: tb/tb_ema_envelope.sv
// Bench for ema_envelope: directed scenarios plus random traffic, each
// cycle checked against an arithmetic EMA model kept in this file.
module tb_ema_envelope;

    localparam int    W   = 27;
    localparam int    S   = 4;
    localparam int    L   = 64;
    localparam longint MAXV = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear_i = 1'b0;
    logic         valid_i = 1'b0;
    logic [W-1:0] mag_i = '0;
    logic         valid_o;
    logic [W-1:0] env_o;
    logic         settled_o;

    int n_vec = 0;
    int n_err = 0;

    // model state
    longint       m_acc = 0;
    bit           m_seeded = 0;
    int           m_upd = 0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_env = '0;
    logic         m_settled = 1'b0;

    ema_envelope #(
        .W_IN        (W),
        .ALPHA_SHIFT (S),
        .SETTLE_LEN  (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_i),
        .valid_i   (valid_i),
        .mag_i     (mag_i),
        .valid_o   (valid_o),
        .env_o     (env_o),
        .settled_o (settled_o)
    );

    // clock
    always #5 clk = ~clk;

    // Envelope seen by the gain controller for a given scaled average.
    function automatic longint model_env(input longint acc);
        longint e;
`ifdef EMA_ROUND_EN
        e = (acc + (64'd1 << (S - 1))) / (64'd1 << S);
        if (e > MAXV) e = MAXV;
`else
        e = acc / (64'd1 << S);
`endif
        return e;
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, settle #1.
    task automatic cycle(input bit v, input bit c, input bit r, input longint m);
        valid_i = v;
        clear_i = c;
        rst     = r;
        mag_i   = W'(m);
        @(posedge clk);
        if (r || c) begin
            m_acc = 0; m_seeded = 0; m_upd = 0;
            m_valid = 1'b0; m_env = '0; m_settled = 1'b0;
        end else if (v) begin
            if (!m_seeded) begin
                m_acc = m * (64'd1 << S);
                m_seeded = 1;
                m_upd = 0;
            end else begin
                m_acc = m_acc - m_acc / (64'd1 << S) + m;
                m_upd++;
                if (m_upd >= L) m_settled = 1'b1;
            end
            m_valid = 1'b1;
            m_env = W'(model_env(m_acc));
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        n_vec++;
        if (valid_o !== 1'b0 || env_o !== '0 || settled_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset got v=%0b env=%0d s=%0b want 0/0/0", valid_o, env_o, settled_o);
        end
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 160);
        n_vec++;
        if (valid_o !== 1'b1 || env_o !== W'(160) || settled_o !== 1'b0) begin
            n_err++;
            $display("FAIL seed got v=%0b env=%0d s=%0b want 1/160/0", valid_o, env_o, settled_o);
        end
    endtask

    task automatic test_decay;
        logic [W-1:0] want2;
`ifdef EMA_ROUND_EN
        want2 = W'(141);
`else
        want2 = W'(140);
`endif
        cycle(1, 0, 0, 0);
        n_vec++;
        if (valid_o !== 1'b1 || env_o !== W'(150)) begin
            n_err++;
            $display("FAIL decay1 got v=%0b env=%0d want 1/150", valid_o, env_o);
        end
        cycle(1, 0, 0, 0);
        n_vec++;
        if (valid_o !== 1'b1 || env_o !== want2) begin
            n_err++;
            $display("FAIL decay2 got v=%0b env=%0d want 1/%0d", valid_o, env_o, want2);
        end
    endtask

    task automatic test_settle;
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 1000);
        for (int i = 0; i < L; i++) begin
            cycle(1, 0, 0, 1000);
            n_vec++;
            if (valid_o !== 1'b1 || env_o !== W'(1000) || settled_o !== (i == L - 1)
                || settled_o !== m_settled) begin
                n_err++;
                $display("FAIL settle[%0d] got v=%0b env=%0d s=%0b want 1/1000/%0b",
                         i, valid_o, env_o, settled_o, (i == L - 1));
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            n_vec++;
            if (valid_o !== 1'b0 || env_o !== W'(1000) || settled_o !== 1'b1) begin
                n_err++;
                $display("FAIL settle_idle[%0d] got v=%0b env=%0d s=%0b want 0/1000/1",
                         i, valid_o, env_o, settled_o);
            end
        end
    endtask

    task automatic test_full_scale;
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 201; i++) begin
            cycle(1, 0, 0, MAXV);
            n_vec++;
            if (valid_o !== 1'b1 || env_o !== W'(MAXV) || env_o !== m_env
                || settled_o !== m_settled) begin
                n_err++;
                $display("FAIL full_scale[%0d] got v=%0b env=%0d s=%0b want 1/%0d/%0b",
                         i, valid_o, env_o, settled_o, MAXV, m_settled);
            end
        end
    endtask

    task automatic test_clear_collision;
        // arrives here in TRACK from the full-scale run
        cycle(1, 1, 0, 500);
        n_vec++;
        if (valid_o !== 1'b0 || env_o !== '0 || settled_o !== 1'b0) begin
            n_err++;
            $display("FAIL clear_coll got v=%0b env=%0d s=%0b want 0/0/0", valid_o, env_o, settled_o);
        end
        cycle(1, 0, 0, 80);
        n_vec++;
        if (valid_o !== 1'b1 || env_o !== W'(80) || settled_o !== 1'b0) begin
            n_err++;
            $display("FAIL clear_reseed got v=%0b env=%0d s=%0b want 1/80/0", valid_o, env_o, settled_o);
        end
    endtask

    task automatic test_gapped;
        cycle(0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 4; j++) begin
                cycle(j == 0, 0, 0, (j == 0) ? 320 : $urandom_range(0, 999));
                n_vec++;
                if (valid_o !== (j == 0) || env_o !== W'(320) || valid_o !== m_valid) begin
                    n_err++;
                    $display("FAIL gapped[%0d.%0d] got v=%0b env=%0d want %0b/320",
                             k, j, valid_o, env_o, (j == 0));
                end
            end
        end
    endtask

    task automatic test_random;
        bit     v, c, r;
        longint m;
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 299) == 0);
            r = ($urandom_range(0, 999) == 0);
            case ($urandom_range(0, 3))
                0:       m = MAXV;
                1:       m = $urandom_range(0, 255);
                default: m = longint'($urandom) & MAXV;
            endcase
            cycle(v, c, r, m);
            n_vec++;
            if (valid_o !== m_valid || env_o !== m_env || settled_o !== m_settled) begin
                n_err++;
                $display("FAIL random[%0d] got v=%0b env=%0d s=%0b want %0b/%0d/%0b",
                         i, valid_o, env_o, settled_o, m_valid, m_env, m_settled);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decay();
        test_settle();
        test_full_scale();
        test_clear_collision();
        test_gapped();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
